// File: rtl/data_ram_ctrl_pkg.sv
// Shared definitions for the data RAM controller: FSM encoding,
// default parameters and the stall-request width.
package data_ram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [63:0] DEF_BASE    = 64'h0000_0000_8000_0000;
    localparam int unsigned DEF_LATENCY = 2;
    localparam int unsigned STALL_W     = 3;
    localparam int unsigned CNT_W       = 3;

    // Unsigned 64-bit window test: base <= addr < limit.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input logic [63:0] limit);
        return (addr >= base) && (addr < limit);
    endfunction

endpackage

// File: rtl/data_ram_array.sv
// DEPTH x 64-bit storage: one byte-masked write port and one registered
// read port. Contents are never reset.
module data_ram_array
    import data_ram_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = 12
) (
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_idx,
    input  logic [63:0]   i_wr_data,
    input  logic [7:0]    i_wr_mask,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_idx,
    output logic [63:0]   o_rd_data
);

    logic [63:0] r_mem [DEPTH];

    // Byte-masked write: only lanes with their mask bit set are updated.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (i_wr_mask[b]) begin
                    r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Registered read; the output register holds its value between reads.
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_idx];
        end
    end

endmodule

// File: rtl/data_ram_ctrl.sv
// Data RAM controller: single-outstanding access, fixed LATENCY from accept
// to a one-cycle response pulse, byte-masked writes, out-of-range errors.
module data_ram_ctrl
    import data_ram_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH   = 4096,
    parameter logic [63:0] BASE    = DEF_BASE,
    parameter int unsigned LATENCY = DEF_LATENCY
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_wen_i,
    input  logic [63:0]        req_addr_i,
    input  logic [63:0]        req_wdata_i,
    input  logic [7:0]         req_wmask_i,
    output logic               resp_valid_o,
    output logic [63:0]        resp_rdata_o,
    output logic               resp_err_o,
    output logic [STALL_W-1:0] stall_flag_o
);

    localparam int unsigned      AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0]      LIMIT    = BASE + 64'(DEPTH) * 64'd8;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic             r_wen;
    logic [63:0]      r_addr;
    logic [63:0]      r_wdata;
    logic [7:0]       r_wmask;

    logic             r_rd_ok;
    logic             r_err;

    logic             w_accept;
    logic             w_enter_resp;
    logic             w_sel_wen;
    logic [63:0]      w_sel_addr;
    logic             w_sel_in_range;
    logic [AW-1:0]    w_sel_idx;
    logic             w_wr_in_range;
    logic [AW-1:0]    w_wr_idx;
    logic             w_arr_we;
    logic             w_arr_re;
    logic [63:0]      w_arr_rdata;

    assign w_accept     = (r_state == ST_IDLE) && req_valid_i;
    assign w_enter_resp = (w_next == ST_RESP);

    // With LATENCY=1 the response is entered straight from the accept edge,
    // before the latches hold the access, so the read port looks at the
    // live request in IDLE and at the latched copy otherwise.
    assign w_sel_wen      = (r_state == ST_IDLE) ? req_wen_i  : r_wen;
    assign w_sel_addr     = (r_state == ST_IDLE) ? req_addr_i : r_addr;
    assign w_sel_in_range = addr_in_range(w_sel_addr, BASE, LIMIT);
    assign w_sel_idx      = AW'((w_sel_addr - BASE) >> 3);

    assign w_wr_in_range  = addr_in_range(r_addr, BASE, LIMIT);
    assign w_wr_idx       = AW'((r_addr - BASE) >> 3);

    // Write commits at the edge that ends RESP, so reset before then drops it.
    assign w_arr_we = (r_state == ST_RESP) && r_wen && w_wr_in_range;
    assign w_arr_re = w_enter_resp && !w_sel_wen && w_sel_in_range;

    data_ram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .i_clk     (clk),
        .i_wr_en   (w_arr_we),
        .i_wr_idx  (w_wr_idx),
        .i_wr_data (r_wdata),
        .i_wr_mask (r_wmask),
        .i_rd_en   (w_arr_re),
        .i_rd_idx  (w_sel_idx),
        .o_rd_data (w_arr_rdata)
    );

    // Next-state and latency counter: BUSY ends when the counter hits zero,
    // which places the response exactly LATENCY cycles after accept.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (LATENCY <= 1) begin
                        w_next = ST_RESP;
                    end else begin
                        w_next     = ST_BUSY;
                        w_cnt_next = CNT_LOAD;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_next     = ST_RESP;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next     = ST_IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    // Handshake, response pulse and stall request, all decoded from state.
    always_comb begin
        req_ready_o  = (r_state == ST_IDLE);
        resp_valid_o = (r_state == ST_RESP);
        stall_flag_o = '0;
        if (rst && (w_accept || (r_state == ST_BUSY))) begin
            stall_flag_o = '1;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Capture the access at the accept edge; later input changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_accept) begin
            r_wen   <= req_wen_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_wmask <= req_wmask_i;
        end
    end

    // Response qualifiers, updated only when a response is entered so the
    // outputs hold until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ok <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_rd_ok <= !w_sel_wen && w_sel_in_range;
            r_err   <= !w_sel_in_range;
        end
    end

    assign resp_rdata_o = r_rd_ok ? w_arr_rdata : '0;
    assign resp_err_o   = r_err;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Self-checking bench: two controllers (LATENCY 2 and 1) checked every cycle
// against a cycle-count reference model, plus directed literal checks.
module tb_data_ram_ctrl;

    localparam int unsigned DEPTH = 256;
    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] LIMIT = BASE + 64'(DEPTH * 8);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vld   [2];
    logic        wen   [2];
    logic [63:0] addr  [2];
    logic [63:0] wdata [2];
    logic [7:0]  wmask [2];
    logic        rdy   [2];
    logic        rv    [2];
    logic        er    [2];
    logic [63:0] rd    [2];
    logic [2:0]  stl   [2];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    data_ram_ctrl #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(2)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid_i(vld[0]), .req_ready_o(rdy[0]), .req_wen_i(wen[0]),
        .req_addr_i(addr[0]), .req_wdata_i(wdata[0]), .req_wmask_i(wmask[0]),
        .resp_valid_o(rv[0]), .resp_rdata_o(rd[0]), .resp_err_o(er[0]),
        .stall_flag_o(stl[0])
    );

    data_ram_ctrl #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid_i(vld[1]), .req_ready_o(rdy[1]), .req_wen_i(wen[1]),
        .req_addr_i(addr[1]), .req_wdata_i(wdata[1]), .req_wmask_i(wmask[1]),
        .resp_valid_o(rv[1]), .resp_rdata_o(rd[1]), .resp_err_o(er[1]),
        .stall_flag_o(stl[1])
    );

    function automatic int unsigned lat_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic bit in_rng(input logic [63:0] a);
        return (a >= BASE) && (a < LIMIT);
    endfunction

    function automatic int unsigned widx(input logic [63:0] a);
        logic [63:0] o;
        o = (a - BASE) >> 3;
        return 32'(o);
    endfunction

    function automatic logic [63:0] rnd_addr();
        case ($urandom_range(0, 9))
            0:       return BASE - 64'($urandom_range(1, 16));
            1:       return LIMIT + 64'($urandom_range(0, 15));
            2:       return {$urandom, $urandom};
            default: return BASE + 64'($urandom_range(0, DEPTH * 8 - 1));
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] mmem [2][DEPTH];
    bit          outst  [2];
    int unsigned tacc   [2];
    bit          m_wen  [2];
    logic [63:0] m_addr [2];
    logic [63:0] m_wdat [2];
    logic [7:0]  m_mask [2];
    logic [63:0] h_rd   [2];
    bit          h_err  [2];
    int unsigned cyc = 0;

    task automatic model_step(input int k);
        bit          resp_now;
        logic [2:0]  e_stall;
        if (!rst) begin
            outst[k] = 1'b0;
            h_rd[k]  = '0;
            h_err[k] = 1'b0;
            chk($sformatf("reset_ready[%0d]", k), rdy[k], 1);
            chk($sformatf("reset_stall[%0d]", k), stl[k], 0);
            chk($sformatf("reset_rvalid[%0d]", k), rv[k], 0);
            chk($sformatf("reset_rdata[%0d]", k), rd[k], 0);
            chk($sformatf("reset_err[%0d]", k), er[k], 0);
            return;
        end
        resp_now = outst[k] && (cyc == tacc[k] + lat_of(k));
        if (resp_now) begin
            if (!in_rng(m_addr[k])) begin
                h_rd[k]  = '0;
                h_err[k] = 1'b1;
            end else begin
                h_err[k] = 1'b0;
                h_rd[k]  = m_wen[k] ? 64'd0 : mmem[k][widx(m_addr[k])];
            end
        end
        e_stall = ((vld[k] && !outst[k]) || (outst[k] && !resp_now)) ? 3'b111 : 3'b000;
        chk($sformatf("ready[%0d]@%0d", k, cyc), rdy[k], !outst[k]);
        chk($sformatf("stall[%0d]@%0d", k, cyc), stl[k], e_stall);
        chk($sformatf("rvalid[%0d]@%0d", k, cyc), rv[k], resp_now);
        chk($sformatf("rdata[%0d]@%0d", k, cyc), rd[k], h_rd[k]);
        chk($sformatf("err[%0d]@%0d", k, cyc), er[k], h_err[k]);
        if (resp_now) begin
            if (m_wen[k] && in_rng(m_addr[k])) begin
                for (int b = 0; b < 8; b++) begin
                    if (m_mask[k][b]) mmem[k][widx(m_addr[k])][b*8 +: 8] = m_wdat[k][b*8 +: 8];
                end
            end
            outst[k] = 1'b0;
        end else if (vld[k] && !outst[k]) begin
            outst[k]  = 1'b1;
            tacc[k]   = cyc;
            m_wen[k]  = wen[k];
            m_addr[k] = addr[k];
            m_wdat[k] = wdata[k];
            m_mask[k] = wmask[k];
        end
    endtask

    // Single compare process: every cycle, both DUTs against the model.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    // ---------------- stimulus ----------------
    task automatic access(input int k, input bit w, input logic [63:0] a,
                          input logic [63:0] d, input logic [7:0] m,
                          output logic [63:0] r, output bit e, output int unsigned lat);
        int unsigned budget;
        r = '0; e = 1'b0; lat = 0;
        @(posedge clk); #1;
        vld[k] = 1'b1; wen[k] = w; addr[k] = a; wdata[k] = d; wmask[k] = m;
        budget = 0;
        while (!rdy[k] && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!rdy[k]) begin
            n_err++;
            $display("FAIL accept_timeout[%0d]: ready stuck at 0, required 1", k);
            vld[k] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Scramble the request lines after accept; they must be ignored.
        vld[k] = 1'b0; wen[k] = 1'($urandom); addr[k] = {$urandom, $urandom};
        wdata[k] = {$urandom, $urandom}; wmask[k] = 8'($urandom);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rv[k]) begin
                lat = i; r = rd[k]; e = er[k];
                break;
            end
        end
        if (lat == 0) begin
            n_err++;
            $display("FAIL resp_timeout[%0d]: no resp_valid within 20 cycles", k);
        end
    endtask

    logic [63:0] r;
    bit          e;
    int unsigned lat;
    int unsigned accepts;
    logic [63:0] a_rst;

    initial begin
        for (int k = 0; k < 2; k++) begin
            vld[k] = 1'b0; wen[k] = 1'b0; addr[k] = '0; wdata[k] = '0; wmask[k] = '0;
        end
        rst = 1'b0;
        vld[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("por_ready", rdy[0], 1);
        chk("por_stall_with_valid", stl[0], 0);
        chk("por_rdata", rd[0], 0);
        vld[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // Fill both arrays so every later read has a defined value.
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < 2; k++) begin
                access(k, 1'b1, BASE + 64'(i * 8), {$urandom, $urandom}, 8'hFF, r, e, lat);
            end
        end

        // Full write then read back at BASE.
        access(0, 1'b1, BASE, 64'h1122334455667788, 8'hFF, r, e, lat);
        chk("wr_latency", lat, 2);
        chk("wr_rdata_zero", r, 0);
        chk("wr_err", e, 0);
        access(0, 1'b0, BASE, 64'h0, 8'h00, r, e, lat);
        chk("rd_latency", lat, 2);
        chk("rd_data", r, 64'h1122334455667788);
        chk("rd_err", e, 0);

        // Partial-mask rewrite.
        access(0, 1'b1, BASE, 64'hAAAAAAAAAAAAAAAA, 8'h0F, r, e, lat);
        access(0, 1'b0, BASE + 64'd5, 64'h0, 8'h00, r, e, lat);
        chk("masked_rd", r, 64'h11223344AAAAAAAA);

        // Out-of-range accesses and a zero-mask write leave the array intact.
        access(0, 1'b0, 64'h7FFFFFF8, 64'h0, 8'h00, r, e, lat);
        chk("oor_rd_err", e, 1);
        chk("oor_rd_data", r, 0);
        access(0, 1'b1, LIMIT, 64'hFFFFFFFFFFFFFFFF, 8'hFF, r, e, lat);
        chk("oor_wr_err", e, 1);
        access(0, 1'b1, BASE, 64'h5555555555555555, 8'h00, r, e, lat);
        chk("mask0_err", e, 0);
        access(0, 1'b0, BASE, 64'h0, 8'h00, r, e, lat);
        chk("unchanged_rd", r, 64'h11223344AAAAAAAA);
        access(0, 1'b0, LIMIT - 64'd1, 64'h0, 8'h00, r, e, lat);
        chk("last_word_err", e, 0);

        // Valid held high: one accept every third cycle.
        accepts = 0;
        @(posedge clk); #1;
        vld[0] = 1'b1; wen[0] = 1'($urandom); addr[0] = rnd_addr();
        wdata[0] = {$urandom, $urandom}; wmask[0] = 8'($urandom);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("stream_stall_%0d", i), stl[0], ((i % 3) != 2) ? 3'b111 : 3'b000);
            if (rdy[0] && vld[0]) accepts++;
            @(posedge clk); #1;
            wen[0] = 1'($urandom); addr[0] = rnd_addr();
            wdata[0] = {$urandom, $urandom}; wmask[0] = 8'($urandom);
        end
        vld[0] = 1'b0;
        chk("stream_accepts", accepts, 4);

        // Reset in the BUSY cycle of a write: the write is discarded.
        a_rst = BASE + 64'h28;
        access(0, 1'b1, a_rst, 64'h0123456789ABCDEF, 8'hFF, r, e, lat);
        @(posedge clk); #1;
        vld[0] = 1'b1; wen[0] = 1'b1; addr[0] = a_rst;
        wdata[0] = 64'hDEADBEEFDEADBEEF; wmask[0] = 8'hFF;
        chk("pre_rst_ready", rdy[0], 1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_ready", rdy[0], 1);
        chk("midrst_stall", stl[0], 0);
        chk("midrst_rvalid", rv[0], 0);
        repeat (2) @(posedge clk);
        #1;
        vld[0] = 1'b0;
        rst = 1'b1;
        access(0, 1'b0, a_rst, 64'h0, 8'h00, r, e, lat);
        chk("post_rst_old_data", r, 64'h0123456789ABCDEF);

        // LATENCY=1 instance, address lines changed right after accept.
        access(1, 1'b1, BASE + 64'h10, 64'hCAFEF00D12345678, 8'hFF, r, e, lat);
        chk("l1_wr_latency", lat, 1);
        access(1, 1'b0, BASE + 64'h13, 64'h0, 8'h00, r, e, lat);
        chk("l1_rd_latency", lat, 1);
        chk("l1_rd_data", r, 64'hCAFEF00D12345678);

        // Random traffic on both instances.
        for (int n = 0; n < 300; n++) begin
            int kk;
            logic [7:0] mm;
            kk = int'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       mm = 8'h00;
                1:       mm = 8'hFF;
                default: mm = 8'($urandom);
            endcase
            access(kk, 1'($urandom), rnd_addr(), {$urandom, $urandom}, mm, r, e, lat);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
